// File: rtl/lfsr_pkg.sv
// Shared definitions for the parametrised LFSR generator: topology encodings,
// default maximal-length tap masks and the Galois mask derivation.
package lfsr_pkg;

    // Feedback topology encodings for the MODE parameter.
    localparam int unsigned LFSR_FIB = 0;
    localparam int unsigned LFSR_GAL = 1;

    // Default maximal-length tap mask for a given width (3..32).
    // Bit i set means the polynomial has an x^(i+1) term.
    function automatic logic [31:0] lfsr_default_taps(input int unsigned width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Galois XOR mask: the taps moved up one place with the x^0 term at bit 0.
    // The caller truncates to WIDTH, which drops the x^WIDTH term.
    function automatic logic [31:0] lfsr_galois_mask(input logic [31:0] taps);
        return (taps << 1) | 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational serial LFSR step in either Fibonacci or Galois form.
// The serial output bit of the step is state_i[WIDTH-1], taken by the caller.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 13,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter int unsigned      MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o
);

    if (MODE == LFSR_GAL) begin : g_galois
        localparam logic [WIDTH-1:0] GMASK = WIDTH'(lfsr_galois_mask(32'(TAPS)));
        assign state_o = {state_i[WIDTH-2:0], 1'b0} ^ ({WIDTH{state_i[WIDTH-1]}} & GMASK);
    end else begin : g_fibonacci
        assign state_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR word generator with valid/ready output, run-time seed
// reload with zero-seed guard, lock-up recovery and period-wrap flag.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 13,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
    parameter int unsigned      MODE     = LFSR_FIB,
    parameter int unsigned      OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic [WIDTH-1:0]    state,
    output logic                seed_err,
    output logic                wrap
);

    logic [WIDTH-1:0]    state_q, state_d;
    logic [WIDTH-1:0]    start_q, start_d;
    logic                valid_q, valid_d;
    logic                seed_err_q, seed_err_d;
    logic                wrap_q, wrap_d;

    logic [WIDTH-1:0]    eff_seed;
    logic [WIDTH-1:0]    adv_state;
    logic [OUT_BITS-1:0] hit;

    // A zero seed would lock the register up, so it is replaced by SEED.
    assign eff_seed = (seed == '0) ? SEED : seed;

    // Unrolled chain of OUT_BITS serial steps; each intermediate state is
    // compared against the start register for the wrap flag.
    for (genvar i = 0; i < OUT_BITS; i++) begin : g_chain
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;

        if (i == 0) begin : g_head
            assign cur = state_q;
        end else begin : g_link
            assign cur = g_chain[i-1].nxt;
        end

        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS),
            .MODE  (MODE)
        ) u_step (
            .state_i (cur),
            .state_o (nxt)
        );

        assign hit[i] = (nxt == start_q);
    end

    assign adv_state = g_chain[OUT_BITS-1].nxt;

    // Next-state selection: load beats lock-up recovery beats the handshake.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path through the block can infer a latch.
        state_d    = state_q;
        start_d    = start_q;
        valid_d    = 1'b1;
        seed_err_d = 1'b0;
        wrap_d     = 1'b0;
        if (load) begin
            state_d    = eff_seed;
            start_d    = eff_seed;
            valid_d    = 1'b0;
            seed_err_d = (seed == '0);
        end else if (state_q == '0) begin
            state_d    = SEED;
            seed_err_d = 1'b1;
        end else if (valid_q && out_ready) begin
            state_d = adv_state;
            wrap_d  = |hit;
        end
    end

    // State, start register and flag flops with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= SEED;
            start_q    <= SEED;
            valid_q    <= 1'b0;
            seed_err_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            valid_q    <= valid_d;
            seed_err_q <= seed_err_d;
            wrap_q     <= wrap_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = state_q[WIDTH-1 -: OUT_BITS];
    assign state     = state_q;
    assign seed_err  = seed_err_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default Fibonacci stream, 4-bit words,
// Galois step, seed loads, wrap period, stall and asynchronous reset.
module tb_lfsr_gen;
    import lfsr_pkg::*;

    logic clk;
    logic rst;

    // Default configuration: Fibonacci, 13 bits, 1 bit per word.
    logic        def_load, def_ready, def_valid, def_serr, def_wrap;
    logic [12:0] def_seed, def_state;
    logic [0:0]  def_data;

    // Four bits per word.
    logic        ob4_load, ob4_ready, ob4_valid, ob4_serr, ob4_wrap;
    logic [12:0] ob4_seed, ob4_state;
    logic [3:0]  ob4_data;

    // Galois topology.
    logic        gal_load, gal_ready, gal_valid, gal_serr, gal_wrap;
    logic [12:0] gal_seed, gal_state;
    logic [0:0]  gal_data;

    int tests = 0;
    int fails = 0;
    int steps = 0;
    int wrap_cnt = 0;
    logic def_live = 1'b0;

    lfsr_gen u_def (
        .clk(clk), .rst(rst), .load(def_load), .seed(def_seed),
        .out_valid(def_valid), .out_ready(def_ready), .out_data(def_data),
        .state(def_state), .seed_err(def_serr), .wrap(def_wrap)
    );

    lfsr_gen #(.OUT_BITS(4)) u_ob4 (
        .clk(clk), .rst(rst), .load(ob4_load), .seed(ob4_seed),
        .out_valid(ob4_valid), .out_ready(ob4_ready), .out_data(ob4_data),
        .state(ob4_state), .seed_err(ob4_serr), .wrap(ob4_wrap)
    );

    lfsr_gen #(.MODE(LFSR_GAL)) u_gal (
        .clk(clk), .rst(rst), .load(gal_load), .seed(gal_seed),
        .out_valid(gal_valid), .out_ready(gal_ready), .out_data(gal_data),
        .state(gal_state), .seed_err(gal_serr), .wrap(gal_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: count a default-DUT handshake at the edge, return at negedge.
    task automatic tick();
        @(posedge clk);
        if (def_live && def_ready) steps++;
        @(negedge clk);
    endtask

    // Hand-derived Fibonacci states from SEED=1 after n serial steps.
    logic [12:0] fib_tbl [17] = '{13'h0001, 13'h0002, 13'h0004, 13'h0008,
                                   13'h0010, 13'h0020, 13'h0040, 13'h0080,
                                   13'h0101, 13'h0202, 13'h0404, 13'h0809,
                                   13'h1013, 13'h0027, 13'h004E, 13'h009C,
                                   13'h0139};
    // Four-bit words at handshake 0..4 (MSB-first packing of the serial stream).
    logic [3:0] ob4_words [5] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h0};

    initial begin
        rst = 1'b1;
        def_load = 1'b0; def_seed = '0; def_ready = 1'b0;
        ob4_load = 1'b0; ob4_seed = '0; ob4_ready = 1'b0;
        gal_load = 1'b0; gal_seed = '0; gal_ready = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_state",    32'(def_state), 32'h0001);
        check("rst_valid",    32'(def_valid), 32'h0);
        check("rst_seed_err", 32'(def_serr),  32'h0);
        check("rst_wrap",     32'(def_wrap),  32'h0);
        check("rst_data",     32'(def_data),  32'h0);
        check("rst_ob4_data", 32'(ob4_data),  32'h0);

        // Release reset; valid rises on the first edge without advancing.
        rst = 1'b0;
        def_ready = 1'b1;
        ob4_ready = 1'b1;
        tick();
        def_live = 1'b1;
        check("first_valid", 32'(def_valid), 32'h1);
        check("first_state", 32'(def_state), 32'h0001);

        // Serial stream and 4-bit packed stream, one word per cycle.
        for (int i = 0; i <= 16; i++) begin
            check($sformatf("fib_state_%0d", i), 32'(def_state), 32'(fib_tbl[i]));
            check($sformatf("fib_bit_%0d", i),   32'(def_data),  (i == 12) ? 32'h1 : 32'h0);
            if (i <= 4) begin
                check($sformatf("ob4_state_%0d", i), 32'(ob4_state), 32'(fib_tbl[4*i]));
                check($sformatf("ob4_word_%0d", i),  32'(ob4_data),  32'(ob4_words[i]));
            end
            tick();
        end

        // Galois: load 0x1000 with a concurrent (discarded) handshake.
        gal_load = 1'b1; gal_seed = 13'h1000; gal_ready = 1'b1;
        tick();
        gal_load = 1'b0;
        check("gal_load_state", 32'(gal_state), 32'h1000);
        check("gal_load_valid", 32'(gal_valid), 32'h0);
        check("gal_load_serr",  32'(gal_serr),  32'h0);
        tick();
        check("gal_valid_back", 32'(gal_valid), 32'h1);
        check("gal_hold_state", 32'(gal_state), 32'h1000);
        check("gal_out_bit",    32'(gal_data),  32'h1);
        tick();
        check("gal_step_state", 32'(gal_state), 32'h1901);
        check("gal_step_wrap",  32'(gal_wrap),  32'h0);

        // Zero-seed load with a handshake in the same cycle.
        gal_load = 1'b1; gal_seed = 13'h0000;
        tick();
        gal_load = 1'b0;
        check("zero_state", 32'(gal_state), 32'h0001);
        check("zero_serr",  32'(gal_serr),  32'h1);
        check("zero_valid", 32'(gal_valid), 32'h0);
        tick();
        check("zero_serr_end",  32'(gal_serr),  32'h0);
        check("zero_valid_end", 32'(gal_valid), 32'h1);
        check("zero_no_adv",    32'(gal_state), 32'h0001);
        gal_ready = 1'b0;

        // Long run: wrap exactly at steps 8191 and 16382.
        for (int cyc = 0; cyc < 40000 && steps < 16394; cyc++) begin
            tick();
            if (def_wrap || steps == 8191 || steps == 16382) begin
                check($sformatf("wrap_at_%0d", steps), 32'(def_wrap),
                      (steps == 8191 || steps == 16382) ? 32'h1 : 32'h0);
                if (def_wrap) begin
                    wrap_cnt++;
                    check($sformatf("wrap_state_%0d", steps), 32'(def_state), 32'h0001);
                end
            end
        end
        check("run_steps",  32'(steps),     32'd16394);
        check("wrap_count", 32'(wrap_cnt),  32'd2);
        check("run_state",  32'(def_state), 32'h1013);
        check("run_data",   32'(def_data),  32'h1);

        // Stall: state and data hold while ready is low.
        def_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("stall_state_%0d", k), 32'(def_state), 32'h1013);
            check($sformatf("stall_data_%0d", k),  32'(def_data),  32'h1);
            check($sformatf("stall_valid_%0d", k), 32'(def_valid), 32'h1);
        end

        // Asynchronous reset between edges, with a load pending.
        def_load = 1'b1; def_seed = 13'h0ABC;
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(def_state), 32'h0001);
        check("arst_valid", 32'(def_valid), 32'h0);
        check("arst_data",  32'(def_data),  32'h0);
        @(negedge clk);
        check("arst_load_ignored", 32'(def_state), 32'h0001);
        def_load = 1'b0;
        rst = 1'b0;
        def_live = 1'b0;
        tick();
        check("post_rst_valid", 32'(def_valid), 32'h1);
        check("post_rst_state", 32'(def_state), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random bit-stream generator and successor to the fixed 13-bit LFSR. Width, tap polynomial, reset seed, feedback topology (Fibonacci or Galois) and bits per output word are all parameters. Words are delivered over a valid/ready handshake, and the seed can be reloaded at run time with an all-zero guard. A period-wrap flag is provided for stimulus generators and self-checking benches.

## Interface
- WIDTH, 13: state width; legal range 3..32.
- TAPS, 13'h1C80: feedback mask. Bit i set means the polynomial has an x^(i+1) term; bit WIDTH-1 must be set. The default encodes x^13+x^12+x^11+x^8+1.
- SEED, 13'd1: reset and fallback state; must be non-zero.
- MODE, 0: 0 selects Fibonacci, 1 selects Galois.
- OUT_BITS, 1: serial steps per output word; legal range 1..WIDTH.

- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- load, input, 1: synchronous seed load; has priority over the handshake.
- seed, input, WIDTH: value loaded when load=1.
- out_valid, output, 1: out_data holds a valid word.
- out_ready, input, 1: consumer accepts the word.
- out_data, output, OUT_BITS: next OUT_BITS bits of the stream, MSB-first.
- state, output, WIDTH: current LFSR register, for debug and verification.
- seed_err, output, 1: one-cycle pulse, zero seed was replaced by SEED.
- wrap, output, 1: one-cycle pulse, sequence returned to its start value.

## Operation
- Single serial step, Fibonacci: next = {s[WIDTH-2:0], ^(s & TAPS)}.
- Single serial step, Galois: next = {s[WIDTH-2:0],1'b0} ^ ({WIDTH{s[WIDTH-1]}} & GMASK).
  - GMASK = {TAPS[WIDTH-2:0],1'b1}, giving 13'h1901 for the default TAPS.
- Serial output bit of each step is s[WIDTH-1], taken before the shift.
- out_data = s[WIDTH-1 -: OUT_BITS], with out_data[OUT_BITS-1] being the oldest bit.
- Handshake: when out_valid & out_ready, the state advances OUT_BITS serial steps in one cycle (combinational unroll). The word stream is bit-identical to OUT_BITS=1 concatenated MSB-first.
- No handshake: state holds and out_data is stable while out_valid=1 and out_ready=0.
- Start register: holds the value the sequence started from. It is set to SEED at reset and updated on every load with the effective seed.
- Load:
  - The state takes seed, or SEED if seed==0; the start register takes the same value.
  - If seed==0, seed_err pulses on the following cycle.
  - out_valid is 0 for the cycle after the load edge.
  - A handshake in the same cycle as load is discarded and does not advance the stream.
- Lock-up guard: if the state is ever all-zero (e.g. an SEU), it is forced to SEED on the next edge and seed_err pulses.
- Wrap: pulses in the cycle after a handshake in which any of the OUT_BITS intermediate states equals the start register.
  - With a maximal polynomial this occurs every 2^WIDTH-1 serial steps.

## Timing
- Reset values: state=SEED, start=SEED, out_valid=0, seed_err=0, wrap=0. out_data reflects SEED.
- out_valid rises on the first rising edge after rst deasserts, then stays 1 except for the post-load cycle.
- seed_err and wrap are registered and last exactly one cycle.
- Back-to-back handshakes give one word per cycle with no bubbles.
- Latency from load to the first valid word is 1 cycle.
- rst asserted mid-stream clears immediately (asynchronously). A load pending at the same time is ignored.
- All outputs are driven from flops except out_data, which is a slice of the state flops.

## Structure
- Shared package lfsr_pkg holds:
  - the MODE encodings: LFSR_FIB=0, LFSR_GAL=1;
  - default tap constants for widths 3..32;
  - the function that derives GMASK from TAPS.
- The sub-module lfsr_step is natural: a combinational single serial step with MODE, WIDTH and TAPS parameters. lfsr_gen instantiates OUT_BITS of them in a chain to perform one handshake's advance.
- The top level holds the state flop, start register, valid/flag flops and the wrap compare across all chain outputs.

## Test plan
- Default parameters, reset released, out_ready=1: after 7 handshakes state=0x0080, after 8 state=0x0101. out_data=0 for the first 8 words.
- OUT_BITS=4, otherwise default: after 2 handshakes state=0x0101, matching 8 serial steps. The word stream equals the OUT_BITS=1 stream packed MSB-first.
- MODE=1, load seed=0x1000, one handshake: state=0x1901 and the out_data bit was 1.
- Load seed=0: next cycle state=0x0001, seed_err=1 for one cycle, out_valid=0 for one cycle. A handshake in the load cycle does not advance the state.
- Default parameters, out_ready=1 continuously from reset: wrap pulses exactly after serial step 8191 and again after 16382, with state=0x0001 at each.
- Hold out_ready=0 for 5 cycles mid-stream, then assert rst asynchronously between edges: state and out_data are stable while stalled; after rst, state=SEED and out_valid=0 immediately.
